// File: rtl/io_ctrl_pkg.sv
// Shared constants and input-side state encoding for the I/O port controller.
package io_ctrl_pkg;

  localparam int DefaultWidth = 8;
  localparam int DefaultDepth = 4;

  typedef enum logic {
    IN_EMPTY = 1'b0,
    IN_FULL  = 1'b1
  } inState_t;

endpackage

// File: rtl/io_port_controller_if.sv
// Core-side and device-side signals of the I/O port controller.
interface io_port_controller_if #(
  parameter int WIDTH = 8
);

  logic             cpu_we;
  logic [WIDTH-1:0] cpu_wdata;
  logic             cpu_rd;
  logic [WIDTH-1:0] cpu_rdata;
  logic             cpu_in_valid;
  logic             cpu_stall;
  logic [WIDTH-1:0] ext_out_data;
  logic             ext_out_valid;
  logic             ext_out_ready;
  logic [WIDTH-1:0] ext_in_data;
  logic             ext_in_valid;
  logic             ext_in_ready;
  logic             err_ovf;
  logic             err_udf;

  // Environment side: drives the processor and external-device inputs.
  modport master (
    output cpu_we, cpu_wdata, cpu_rd, ext_out_ready, ext_in_data, ext_in_valid,
    input  cpu_rdata, cpu_in_valid, cpu_stall, ext_out_data, ext_out_valid,
    input  ext_in_ready, err_ovf, err_udf
  );

  // Controller side.
  modport slave (
    input  cpu_we, cpu_wdata, cpu_rd, ext_out_ready, ext_in_data, ext_in_valid,
    output cpu_rdata, cpu_in_valid, cpu_stall, ext_out_data, ext_out_valid,
    output ext_in_ready, err_ovf, err_udf
  );

endinterface

// File: rtl/io_out_fifo.sv
// Output FIFO: storage, wrapping pointers, occupancy count and full/empty decode.
module io_out_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic             pushDrop
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FullCount = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rdPtr;
  logic [PW-1:0]    wrPtr;
  logic [PW:0]      count;
  logic             doPush;
  logic             doPop;

  // Full is taken from the registered count, so a pop in the same cycle
  // does not make room for a write.
  assign full     = (count == FullCount);
  assign empty    = (count == '0);
  assign doPush   = push && !full;
  assign doPop    = pop && !empty;
  assign pushDrop = push && full;
  assign rdata    = empty ? '0 : mem[rdPtr];

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + PW'(1);
      if (doPop)  rdPtr <= rdPtr + PW'(1);
      case ({doPush, doPop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/io_port_controller.sv
// I/O port controller: buffered output path, one-entry input holding register,
// sticky overflow/underflow flags.
module io_port_controller
  import io_ctrl_pkg::*;
#(
  parameter int WIDTH = DefaultWidth,
  parameter int DEPTH = DefaultDepth
) (
  input  logic                 clk,
  input  logic                 rst_n,
  io_port_controller_if.slave  bus
);

  inState_t         state;
  inState_t         nextState;
  logic             capture;
  logic             underflow;
  logic             fifoFull;
  logic             fifoEmpty;
  logic             pushDrop;
  logic [WIDTH-1:0] heldByte;
  logic             errOvf;
  logic             errUdf;

  io_out_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) uOutFifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (bus.cpu_we),
    .pop      (bus.ext_out_ready && !fifoEmpty),
    .wdata    (bus.cpu_wdata),
    .rdata    (bus.ext_out_data),
    .full     (fifoFull),
    .empty    (fifoEmpty),
    .pushDrop (pushDrop)
  );

  assign bus.ext_out_valid = !fifoEmpty;
  assign bus.cpu_stall     = fifoFull;
  assign bus.ext_in_ready  = (state == IN_EMPTY);
  assign bus.cpu_in_valid  = (state == IN_FULL);
  assign bus.cpu_rdata     = heldByte;
  assign bus.err_ovf       = errOvf;
  assign bus.err_udf       = errUdf;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IN_EMPTY;
      heldByte <= '0;
      errOvf   <= 1'b0;
      errUdf   <= 1'b0;
    end else begin
      state <= nextState;
      if (capture)   heldByte <= bus.ext_in_data;
      if (pushDrop)  errOvf   <= 1'b1;
      if (underflow) errUdf   <= 1'b1;
    end
  end

  // No same-cycle refill: a consumed byte frees the register for the next cycle.
  always_comb begin
    nextState = state;
    capture   = 1'b0;
    underflow = 1'b0;
    case (state)
      IN_EMPTY: begin
        underflow = bus.cpu_rd;
        if (bus.ext_in_valid) begin
          capture   = 1'b1;
          nextState = IN_FULL;
        end
      end
      IN_FULL: begin
        if (bus.cpu_rd) nextState = IN_EMPTY;
      end
      default: nextState = IN_EMPTY;
    endcase
  end

endmodule

// File: tb/tb_io_port_controller.sv
// Scoreboard bench for io_port_controller: directed stimulus, queued expectations.
module tb_io_port_controller;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  int   cycles = 0;

  logic [7:0] outQ[$];
  logic [7:0] inQ[$];
  logic [7:0] expOut;
  logic [7:0] expIn;

  io_port_controller_if #(.WIDTH(8)) bus ();

  io_port_controller #(.WIDTH(8), .DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cycles++;
    if (cycles > 5000) begin
      $display("FAIL watchdog: cycles %0d limit 5000", cycles);
      $fatal(1, "watchdog expired");
    end
  end

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Monitor: compares every accepted output byte and every consumed input byte.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.ext_out_valid && bus.ext_out_ready) begin
        if (outQ.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL outUnexpected: got %02h expected no transfer", bus.ext_out_data);
        end else begin
          expOut = outQ.pop_front();
          check8("outData", bus.ext_out_data, expOut);
        end
      end
      if (bus.cpu_in_valid && bus.cpu_rd) begin
        if (inQ.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL inUnexpected: got %02h expected no byte", bus.cpu_rdata);
        end else begin
          expIn = inQ.pop_front();
          check8("inData", bus.cpu_rdata, expIn);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    tick();
    tick();
    outQ.delete();
    inQ.delete();
    rst_n = 1'b1;
  endtask

  task automatic write(input logic [7:0] b, input bit expectAccept);
    bus.cpu_we    = 1'b1;
    bus.cpu_wdata = b;
    if (expectAccept) outQ.push_back(b);
    tick();
    bus.cpu_we = 1'b0;
  endtask

  task automatic checkIdle(input string tag);
    check1({tag, "_outValid"}, bus.ext_out_valid, 1'b0);
    check8({tag, "_outData"},  bus.ext_out_data,  8'h00);
    check1({tag, "_stall"},    bus.cpu_stall,     1'b0);
    check1({tag, "_inValid"},  bus.cpu_in_valid,  1'b0);
    check8({tag, "_rdata"},    bus.cpu_rdata,     8'h00);
    check1({tag, "_inReady"},  bus.ext_in_ready,  1'b1);
    check1({tag, "_errOvf"},   bus.err_ovf,       1'b0);
    check1({tag, "_errUdf"},   bus.err_udf,       1'b0);
  endtask

  initial begin
    bus.cpu_we        = 1'b0;
    bus.cpu_wdata     = 8'h00;
    bus.cpu_rd        = 1'b0;
    bus.ext_out_ready = 1'b0;
    bus.ext_in_data   = 8'h00;
    bus.ext_in_valid  = 1'b0;

    // Reset then idle
    doReset();
    tick();
    checkIdle("reset");

    // Fill to full, overflow, then drain
    write(8'h11, 1);
    check1("firstValid", bus.ext_out_valid, 1'b1);
    check8("firstHead", bus.ext_out_data, 8'h11);
    write(8'h22, 1);
    write(8'h33, 1);
    check1("stallAt3", bus.cpu_stall, 1'b0);
    write(8'h44, 1);
    check1("stallAt4", bus.cpu_stall, 1'b1);
    write(8'h55, 0);
    check1("ovfSet", bus.err_ovf, 1'b1);
    check8("headHeld", bus.ext_out_data, 8'h11);
    check1("stillFull", bus.cpu_stall, 1'b1);
    bus.ext_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check1("drainedValid", bus.ext_out_valid, 1'b0);
    check1("drainedStall", bus.cpu_stall, 1'b0);
    check8("drainQueue", 8'(outQ.size()), 8'd0);

    // Full with a pop and a write in the same cycle: write dropped
    bus.ext_out_ready = 1'b0;
    doReset();
    write(8'h11, 1);
    write(8'h22, 1);
    write(8'h33, 1);
    write(8'h44, 1);
    bus.ext_out_ready = 1'b1;
    write(8'h66, 0);
    bus.ext_out_ready = 1'b0;
    check1("popDropOvf", bus.err_ovf, 1'b1);
    check1("popDropStall", bus.cpu_stall, 1'b0);
    check8("popDropHead", bus.ext_out_data, 8'h22);
    bus.ext_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check1("popDropEmpty", bus.ext_out_valid, 1'b0);

    // Simultaneous push/pop at count 2, then drain across pointer wrap
    bus.ext_out_ready = 1'b0;
    doReset();
    write(8'h01, 1);
    write(8'h02, 1);
    write(8'h03, 1);
    bus.ext_out_ready = 1'b1;
    tick();
    write(8'h77, 1);
    bus.ext_out_ready = 1'b0;
    check8("wrapHead", bus.ext_out_data, 8'h03);
    write(8'h88, 1);
    check1("wrapCount3", bus.cpu_stall, 1'b0);
    write(8'h99, 1);
    check1("wrapCount4", bus.cpu_stall, 1'b1);
    check1("wrapNoOvf", bus.err_ovf, 1'b0);
    bus.ext_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    bus.ext_out_ready = 1'b0;
    check1("wrapEmpty", bus.ext_out_valid, 1'b0);
    check8("wrapQueue", 8'(outQ.size()), 8'd0);

    // Input holding register
    bus.ext_in_valid = 1'b1;
    bus.ext_in_data  = 8'hA5;
    inQ.push_back(8'hA5);
    tick();
    bus.ext_in_data = 8'h5A;
    check1("inValidA5", bus.cpu_in_valid, 1'b1);
    check8("rdataA5", bus.cpu_rdata, 8'hA5);
    check1("inReadyLow", bus.ext_in_ready, 1'b0);
    tick();
    tick();
    check8("heldOff", bus.cpu_rdata, 8'hA5);
    bus.cpu_rd = 1'b1;
    tick();
    bus.cpu_rd = 1'b0;
    check1("readyAfterRd", bus.ext_in_ready, 1'b1);
    check1("validAfterRd", bus.cpu_in_valid, 1'b0);
    check8("rdataKept", bus.cpu_rdata, 8'hA5);
    inQ.push_back(8'h5A);
    tick();
    bus.ext_in_valid = 1'b0;
    check1("inValid5A", bus.cpu_in_valid, 1'b1);
    check8("rdata5A", bus.cpu_rdata, 8'h5A);
    bus.cpu_rd = 1'b1;
    tick();
    bus.cpu_rd = 1'b0;
    check1("noUdfYet", bus.err_udf, 1'b0);

    // Read while empty
    bus.cpu_rd = 1'b1;
    tick();
    bus.cpu_rd = 1'b0;
    check1("udfSet", bus.err_udf, 1'b1);
    check8("udfRdata", bus.cpu_rdata, 8'h5A);
    check1("udfState", bus.cpu_in_valid, 1'b0);
    check8("inQueue", 8'(inQ.size()), 8'd0);

    // Reset mid-drain with a held input byte and overflow set
    bus.ext_in_valid = 1'b1;
    bus.ext_in_data  = 8'h3C;
    tick();
    bus.ext_in_valid = 1'b0;
    write(8'hC1, 1);
    write(8'hC2, 1);
    write(8'hC3, 1);
    write(8'hC4, 1);
    write(8'hC5, 0);
    bus.ext_out_ready = 1'b1;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    outQ.delete();
    inQ.delete();
    bus.ext_out_ready = 1'b0;
    checkIdle("midReset");
    rst_n = 1'b1;
    tick();
    check1("postResetValid", bus.ext_out_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/io_port_controller.md
# io_port_controller

Sequences the processor's I/O path between the core and external devices. Processor writes to the output port are buffered in a small FIFO and drained to the external device with a valid/ready handshake. Input bytes from the external device are captured by a one-entry holding register and presented to the core until it acknowledges the read. The block raises a stall when the core cannot write, and keeps sticky overflow and underflow flags.

## Interface
Parameters:
- WIDTH, 8, data width of every data port.
- DEPTH, 4, output FIFO depth; must be a power of 2 and ≥ 2.

Ports:
- clk  in  1  single clock; all state updates on posedge clk.
- rst_n  in  1  synchronous reset, active-low; sampled on posedge clk.
- cpu_we  in  1  processor output-write enable.
- cpu_wdata  in  WIDTH  byte written by the processor.
- cpu_rd  in  1  processor consumes the current input byte (1-cycle pulse).
- cpu_rdata  out  WIDTH  held input byte.
- cpu_in_valid  out  1  cpu_rdata holds an unconsumed byte.
- cpu_stall  out  1  output FIFO full; processor must hold its write.
- ext_out_data  out  WIDTH  FIFO head byte.
- ext_out_valid  out  1  FIFO non-empty.
- ext_out_ready  in  1  external device accepts ext_out_data.
- ext_in_data  in  WIDTH  byte from the external device.
- ext_in_valid  in  1  ext_in_data is valid.
- ext_in_ready  out  1  holding register empty; capture allowed.
- err_ovf  out  1  sticky: a write was dropped because the FIFO was full.
- err_udf  out  1  sticky: cpu_rd was asserted with no byte held.

## Operation
Reset values (rst_n low at posedge):
- FIFO count, read pointer and write pointer are 0.
- Outputs: ext_out_valid=0, ext_out_data=0, cpu_stall=0, cpu_in_valid=0, cpu_rdata=0, ext_in_ready=1, err_ovf=0, err_udf=0.
- Reset mid-transfer discards all FIFO contents and any held input byte.

Output FIFO:
- Push: cpu_we && count<DEPTH. Pop: ext_out_valid && ext_out_ready.
- Full is evaluated on the registered count. A write at count==DEPTH is dropped and sets err_ovf, even if a pop occurs in the same cycle.
- Simultaneous push and pop with 0<count<DEPTH: count is unchanged and both pointers advance.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Count is log2(DEPTH)+1 bits.
- ext_out_data = mem[rd_ptr]. It must stay stable while ext_out_valid=1 and ext_out_ready=0.
- cpu_stall = (count==DEPTH). This is combinational from a register, with no input-to-output path.

Input FSM, states IN_EMPTY and IN_FULL:
- IN_EMPTY: ext_in_ready=1. If ext_in_valid: capture cpu_rdata<=ext_in_data and go to IN_FULL.
- IN_FULL: ext_in_ready=0, cpu_in_valid=1. If cpu_rd: go to IN_EMPTY; cpu_rdata keeps its last value.
- cpu_rd in IN_EMPTY sets err_udf. State and cpu_rdata are unchanged.
- There is no same-cycle refill. Maximum input throughput is one byte per two cycles.

Error flags are cleared only by reset.

## Timing
- Write latency: cpu_we at edge k with empty FIFO gives ext_out_valid=1 and ext_out_data=byte during cycle k+1.
- Drain: with ext_out_ready held high, one byte per cycle.
- Input latency: capture at edge k gives cpu_in_valid=1 during cycle k+1. cpu_rd at edge m gives ext_in_ready=1 during cycle m+1.
- All outputs are registered or decoded from registers only. No combinational in-to-out paths.

## Structure
- Shared package io_ctrl_pkg: the input state encoding (IN_EMPTY=1'b0, IN_FULL=1'b1) and the default WIDTH and DEPTH constants.
- Sub-module io_out_fifo(WIDTH, DEPTH):
  - contains storage, pointers, count and the full/empty decode;
  - exposes push, pop, wdata, rdata, full, empty and push_drop.
- The top level holds the input FSM, the holding register and the error flags.

## Test plan
- Reset then idle: all outputs match the reset values, and ext_in_ready=1.
- Writes 0x11,0x22,0x33,0x44 with ext_out_ready=0:
  - cpu_stall=1 after the 4th write;
  - a 5th write of 0x55 leaves the FIFO contents unchanged and sets err_ovf;
  - then raising ext_out_ready drains 0x11,0x22,0x33,0x44 on consecutive cycles, and ext_out_valid drops after 0x44.
- FIFO at count=4 with ext_out_ready=1 and cpu_we(0x66) in the same cycle: the write is dropped, err_ovf=1, count=3.
- FIFO at count=2, simultaneous push 0x77 and pop: count stays 2, and the sequence drains in order across pointer wrap.
- Input byte 0xA5:
  - ext_in_valid with 0xA5 gives cpu_in_valid=1, cpu_rdata=0xA5 and ext_in_ready=0;
  - a second byte 0x5A is held off until cpu_rd, then captured two cycles later.
- cpu_rd while empty sets err_udf=1 with cpu_rdata unchanged. Asserting rst_n=0 mid-drain clears the FIFO, flags and FSM in one cycle.
